// File: rtl/digital_pll_pkg.sv
// Shared definitions for the PLL ring-oscillator trim bus.
// Used by the trim monitor and the PLL controller encoder.
//   TRIM_W / TINT_W / TINT_MAX : bus and code widths, largest code
//   HALF_ORDER                 : order in which bits of one 13-bit half are switched on
//   mon_state_t                : trim monitor FSM states
//   trim_encode()              : integer code -> trim bus value
//   tint_absdiff()             : |a-b| on codes without wrap
package digital_pll_pkg;

   localparam int TRIM_W   = 26;
   localparam int TINT_W   = 5;
   localparam int TINT_MAX = 26;
   localparam int HALF_W   = 13;

   localparam logic [4:0] HALF_ORDER [HALF_W] = '{
      5'd0, 5'd6, 5'd10, 5'd3, 5'd8, 5'd12, 5'd5, 5'd2, 5'd9, 5'd4, 5'd11, 5'd1, 5'd7
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_t;

   // Code k switches on k bits: the first half fills in HALF_ORDER,
   // then the second half fills in the same order offset by 13.
   function automatic logic [TRIM_W-1:0] trim_encode(input logic [TINT_W-1:0] code);
      logic [TRIM_W-1:0] t;
      t = '0;
      for (int i = 0; i < HALF_W; i++) begin
         if (i < int'(code))
            t[HALF_ORDER[4'(i)]] = 1'b1;
         if (i + HALF_W < int'(code))
            t[HALF_ORDER[4'(i)] + 5'd13] = 1'b1;
      end
      return t;
   endfunction

   function automatic logic [TINT_W:0] tint_absdiff(input logic [TINT_W-1:0] a,
                                                    input logic [TINT_W-1:0] b);
      logic [TINT_W:0] ea;
      logic [TINT_W:0] eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      return (ea > eb) ? (ea - eb) : (eb - ea);
   endfunction

endpackage

// File: rtl/digital_pll_trim_decode.sv
// Combinational trim bus decoder.
//   trim_i  : registered trim bus
//   valid_o : trim_i matches exactly one encoder table entry
//   tint_o  : integer code of the matching entry (0 when not valid)
module digital_pll_trim_decode
   import digital_pll_pkg::*;
(
   input  logic [TRIM_W-1:0] trim_i,
   output logic              valid_o,
   output logic [TINT_W-1:0] tint_o
);

   // Table entries are distinct, so at most one compare can hit.
   always_comb begin
      valid_o = 1'b0;
      tint_o  = '0;
      for (int k = 0; k <= TINT_MAX; k++) begin
         if (trim_i == trim_encode(5'(k))) begin
            valid_o = 1'b1;
            tint_o  = 5'(k);
         end
      end
   end

endmodule

// File: rtl/digital_pll_trim_monitor.sv
// Observer for the PLL ring-oscillator trim bus: decodes the code, flags
// illegal bus values, tracks frequency lock and keeps min/max/change stats.
//   clock, reset            : PLL clock, async active-high reset
//   enable_i, clear_i       : run enable, sync clear of stats/flags/FSM
//   trim_i                  : trim bus from the PLL controller
//   tint_out_o, code_error_o: decoded code of last valid trim, illegal-value flag
//   error_sticky_o          : any illegal value seen since clear
//   locked_o, lock_lost_o   : lock indication, sticky lock-lost-by-deviation
//   tint_min_o, tint_max_o  : code range since clear
//   change_cnt_o            : saturating count of code changes
//
// state   | meaning
// IDLE    | monitor disabled, not locked
// ACQUIRE | counting consecutive samples within LOCK_TOL of ref
// LOCKED  | locked while samples stay within UNLOCK_TOL of ref
module digital_pll_trim_monitor
   import digital_pll_pkg::*;
#(
   parameter int LOCK_CYCLES = 256,
   parameter int LOCK_TOL    = 1,
   parameter int UNLOCK_TOL  = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic [TRIM_W-1:0] trim_i,
   output logic [TINT_W-1:0] tint_out_o,
   output logic              code_error_o,
   output logic              error_sticky_o,
   output logic              locked_o,
   output logic              lock_lost_o,
   output logic [TINT_W-1:0] tint_min_o,
   output logic [TINT_W-1:0] tint_max_o,
   output logic [CNT_W-1:0]  change_cnt_o
);

   localparam int STB_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

   logic [TRIM_W-1:0] trim_q;
   logic              dec_valid;
   logic [TINT_W-1:0] dec_tint;
   logic [TINT_W:0]   dev;
   logic              hit_acq, hit_lock;

   logic [TINT_W-1:0] tint_q, tint_d, min_q, min_d, max_q, max_d, ref_q, ref_d;
   logic              err_q, err_d, sticky_q, sticky_d, lost_q, lost_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STB_W-1:0]  stable_q, stable_d;
   mon_state_t        state_q, state_d;

   digital_pll_trim_decode u_decode (
      .trim_i  (trim_q),
      .valid_o (dec_valid),
      .tint_o  (dec_tint)
   );

   assign dev      = tint_absdiff(dec_tint, ref_q);
   assign hit_acq  = dec_valid && (dev <= 6'(LOCK_TOL));
   assign hit_lock = dec_valid && (dev <= 6'(UNLOCK_TOL));

   // tint_out and code_error track the pipeline regardless of enable;
   // only the statistics are frozen while disabled.
   always_comb begin
      tint_d   = tint_q;
      err_d    = ~dec_valid;
      sticky_d = sticky_q | ~dec_valid;
      min_d    = min_q;
      max_d    = max_q;
      cnt_d    = cnt_q;
      if (dec_valid)
         tint_d = dec_tint;
      if (enable_i && dec_valid) begin
         if (dec_tint < min_q)
            min_d = dec_tint;
         if (dec_tint > max_q)
            max_d = dec_tint;
         if ((dec_tint != tint_q) && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
      end
      if (clear_i) begin
         sticky_d = 1'b0;
         min_d    = TINT_W'(TINT_MAX);
         max_d    = '0;
         cnt_d    = '0;
      end
   end

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      stable_d = stable_q;
      lost_d   = lost_q;
      if (clear_i) begin
         state_d  = enable_i ? ACQUIRE : IDLE;
         stable_d = '0;
         lost_d   = 1'b0;
         if (dec_valid)
            ref_d = dec_tint;
      end else if (!enable_i) begin
         state_d  = IDLE;
         stable_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = ACQUIRE;
               stable_d = '0;
               if (dec_valid)
                  ref_d = dec_tint;
            end
            ACQUIRE: begin
               if (hit_acq) begin
                  if (stable_q == STB_W'(LOCK_CYCLES - 1)) begin
                     state_d  = LOCKED;
                     stable_d = '0;
                  end else begin
                     stable_d = stable_q + 1'b1;
                  end
               end else begin
                  stable_d = '0;
                  if (dec_valid)
                     ref_d = dec_tint;
               end
            end
            LOCKED: begin
               if (!hit_lock) begin
                  state_d  = ACQUIRE;
                  stable_d = '0;
                  lost_d   = 1'b1;
                  if (dec_valid)
                     ref_d = dec_tint;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trim_q   <= '0;
         tint_q   <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         min_q    <= TINT_W'(TINT_MAX);
         max_q    <= '0;
         cnt_q    <= '0;
         state_q  <= IDLE;
         ref_q    <= '0;
         stable_q <= '0;
         lost_q   <= 1'b0;
      end else begin
         trim_q   <= trim_i;
         tint_q   <= tint_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         min_q    <= min_d;
         max_q    <= max_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         ref_q    <= ref_d;
         stable_q <= stable_d;
         lost_q   <= lost_d;
      end
   end

   assign tint_out_o     = tint_q;
   assign code_error_o   = err_q;
   assign error_sticky_o = sticky_q;
   assign locked_o       = (state_q == LOCKED);
   assign lock_lost_o    = lost_q;
   assign tint_min_o     = min_q;
   assign tint_max_o     = max_q;
   assign change_cnt_o   = cnt_q;

endmodule

// File: tb/tb_digital_pll_trim_monitor.sv
module tb_digital_pll_trim_monitor;

   localparam int LC = 256;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        clear;
   logic [25:0] trim;
   logic [4:0]  tint_out;
   logic        code_error;
   logic        error_sticky;
   logic        locked;
   logic        lock_lost;
   logic [4:0]  tint_min;
   logic [4:0]  tint_max;
   logic [15:0] change_cnt;

   digital_pll_trim_monitor dut (
      .clock          (clock),
      .reset          (reset),
      .enable_i       (enable),
      .clear_i        (clear),
      .trim_i         (trim),
      .tint_out_o     (tint_out),
      .code_error_o   (code_error),
      .error_sticky_o (error_sticky),
      .locked_o       (locked),
      .lock_lost_o    (lock_lost),
      .tint_min_o     (tint_min),
      .tint_max_o     (tint_max),
      .change_cnt_o   (change_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] tint;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   logic [4:0] last_valid;
   int         checks = 0;
   int         errors = 0;
   int         ord [13] = '{0, 6, 10, 3, 8, 12, 5, 2, 9, 4, 11, 1, 7};

   function automatic logic [25:0] enc(input int k);
      logic [25:0] t;
      t = '0;
      for (int i = 0; i < 13; i++) begin
         if (i < k)      t = t | (26'd1 << ord[4'(i)]);
         if (i + 13 < k) t = t | (26'd1 << (ord[4'(i)] + 13));
      end
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_restart();
      exp_t e;
      sb.delete();
      last_valid = 5'd0;
      e.tint = 5'd0;
      e.err  = 1'b0;
      sb.push_back(e);
   endtask

   // Drive one trim value for one cycle; outputs for the value driven one
   // step earlier appear after this edge.
   task automatic step(input logic [25:0] t);
      exp_t e;
      logic v;
      int   k;
      trim = t;
      v = 1'b0;
      k = 0;
      for (int c = 0; c <= 26; c++)
         if (t == enc(c)) begin
            v = 1'b1;
            k = c;
         end
      if (v) last_valid = 5'(k);
      e.tint = last_valid;
      e.err  = ~v;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() >= 2) begin
         e = sb.pop_front();
         chk("tint_out", 32'(tint_out), 32'(e.tint));
         chk("code_error", 32'(code_error), 32'(e.err));
      end
   endtask

   task automatic check_reset_state();
      chk("rst_tint_out", 32'(tint_out), 32'd0);
      chk("rst_code_error", 32'(code_error), 32'd0);
      chk("rst_error_sticky", 32'(error_sticky), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_lock_lost", 32'(lock_lost), 32'd0);
      chk("rst_tint_min", 32'(tint_min), 32'd26);
      chk("rst_tint_max", 32'(tint_max), 32'd0);
      chk("rst_change_cnt", 32'(change_cnt), 32'd0);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      clear  = 1'b0;
      trim   = '0;
      repeat (2) @(posedge clock);
      #1;
      check_reset_state();
      reset = 1'b0;
      sb_restart();

      // code 0 held: lock exactly LC+1 edges after enable
      enable = 1'b1;
      for (int j = 1; j <= LC + 1; j++) begin
         step(enc(0));
         if (j == LC)     chk("lock0_early", 32'(locked), 32'd0);
         if (j == LC + 1) chk("lock0_edge", 32'(locked), 32'd1);
      end

      // sweep all codes
      for (int c = 0; c <= 26; c++) step(enc(c));
      step(enc(26));
      chk("sweep_change_cnt", 32'(change_cnt), 32'd26);
      chk("sweep_min", 32'(tint_min), 32'd0);
      chk("sweep_max", 32'(tint_max), 32'd26);
      chk("sweep_sticky", 32'(error_sticky), 32'd0);

      // clear wins over the same-edge stats update of code 26
      clear = 1'b1;
      step(enc(13));
      clear = 1'b0;
      chk("clr_cnt", 32'(change_cnt), 32'd0);
      chk("clr_min", 32'(tint_min), 32'd26);
      chk("clr_max", 32'(tint_max), 32'd0);
      chk("clr_lost", 32'(lock_lost), 32'd0);
      for (int j = 1; j <= LC + 2; j++) step(enc(13));
      chk("lock13", 32'(locked), 32'd1);
      chk("lock13_min", 32'(tint_min), 32'd13);
      chk("lock13_max", 32'(tint_max), 32'd13);
      chk("lock13_cnt", 32'(change_cnt), 32'd1);

      // deviation of 2 tolerated, 3 loses lock
      repeat (3) step(enc(15));
      chk("dev2_locked", 32'(locked), 32'd1);
      chk("dev2_lost", 32'(lock_lost), 32'd0);
      step(enc(16));
      step(enc(16));
      chk("dev3_locked", 32'(locked), 32'd0);
      chk("dev3_lost", 32'(lock_lost), 32'd1);
      for (int j = 1; j <= LC; j++) begin
         step(enc(16));
         if (j == LC - 1) chk("relock16_early", 32'(locked), 32'd0);
         if (j == LC)     chk("relock16", 32'(locked), 32'd1);
      end
      chk("relock16_lost", 32'(lock_lost), 32'd1);

      // clear while locked
      clear = 1'b1;
      step(enc(16));
      clear = 1'b0;
      chk("clrlk_locked", 32'(locked), 32'd0);
      chk("clrlk_lost", 32'(lock_lost), 32'd0);
      chk("clrlk_min", 32'(tint_min), 32'd26);
      chk("clrlk_cnt", 32'(change_cnt), 32'd0);
      for (int j = 1; j <= LC; j++) begin
         step(enc(16));
         if (j == LC - 1) chk("clrlk_relock_early", 32'(locked), 32'd0);
         if (j == LC)     chk("clrlk_relock", 32'(locked), 32'd1);
      end

      // single invalid value while locked
      step(26'h0000040);
      step(enc(16));
      chk("inv_locked", 32'(locked), 32'd0);
      chk("inv_lost", 32'(lock_lost), 32'd1);
      chk("inv_sticky", 32'(error_sticky), 32'd1);
      step(enc(16));
      chk("inv_cnt", 32'(change_cnt), 32'd0);
      chk("inv_sticky_hold", 32'(error_sticky), 32'd1);

      // alternating 12/13 acquisition
      step(enc(12));
      step(enc(12));
      clear = 1'b1;
      step(enc(12));
      clear = 1'b0;
      for (int a = 1; a <= LC; a++) begin
         step(enc((a % 2 == 1) ? 13 : 12));
         if (a == LC - 1) chk("alt_early", 32'(locked), 32'd0);
         if (a == LC)     chk("alt_lock", 32'(locked), 32'd1);
      end
      chk("alt_cnt", 32'(change_cnt), 32'(LC - 1));
      chk("alt_min", 32'(tint_min), 32'd12);
      chk("alt_max", 32'(tint_max), 32'd13);

      // disable: unlock, lock_lost unchanged, stats frozen
      enable = 1'b0;
      step(enc(12));
      chk("dis_locked", 32'(locked), 32'd0);
      chk("dis_lost", 32'(lock_lost), 32'd0);
      chk("dis_cnt", 32'(change_cnt), 32'(LC - 1));
      enable = 1'b1;

      // 15 injected at hit 200 restarts acquisition
      clear = 1'b1;
      step(enc(12));
      clear = 1'b0;
      for (int a = 1; a <= 202 + LC; a++) begin
         step(enc((a == 200) ? 15 : ((a % 2 == 1) ? 13 : 12)));
         if (a == LC)           chk("glitch_nolock", 32'(locked), 32'd0);
         if (a == 201 + LC)     chk("glitch_early", 32'(locked), 32'd0);
         if (a == 202 + LC)     chk("glitch_lock", 32'(locked), 32'd1);
      end

      // async reset mid-acquire
      clear = 1'b1;
      step(enc(20));
      clear = 1'b0;
      repeat (5) step(enc(20));
      #3;
      reset = 1'b1;
      #1;
      check_reset_state();
      @(posedge clock);
      #1;
      reset = 1'b0;
      sb_restart();
      step(enc(5));
      step(enc(5));
      step(enc(5));
      chk("post_rst_locked", 32'(locked), 32'd0);
      chk("post_rst_cnt", 32'(change_cnt), 32'd1);
      chk("post_rst_min", 32'(tint_min), 32'd0);
      chk("post_rst_max", 32'(tint_max), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
